// File: rtl/l2_flush_ctrl_pkg.sv
// Shared constants, types and helpers for the L2 flush controller.
package l2_flush_ctrl_pkg;

   localparam int L2_SETS_DFLT  = 4;
   localparam int L2_WAYS_DFLT  = 2;
   localparam int N_REQS_DFLT   = 4;
   localparam int CNT_BITS_DFLT = 16;

   localparam int L2_SET_BITS  = $clog2(L2_SETS_DFLT);
   localparam int L2_WAY_BITS  = $clog2(L2_WAYS_DFLT);
   localparam int REQS_BITS_P1 = $clog2(N_REQS_DFLT) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } l2_flush_state_t;

   // Width of a cursor that must be able to hold the value n itself
   // (one past the last index), not just 0..n-1.
   function automatic int cursor_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/l2_flush_ctrl_if.sv
// Decoder / datapath / CPU-side signal bundle of the L2 flush controller.
// The master side is the decoder and its neighbours; the slave side is the controller.
interface l2_flush_ctrl_if
   import l2_flush_ctrl_pkg::*;
#(
   parameter int L2_SETS  = L2_SETS_DFLT,
   parameter int L2_WAYS  = L2_WAYS_DFLT,
   parameter int N_REQS   = N_REQS_DFLT,
   parameter int CNT_BITS = CNT_BITS_DFLT
);

   localparam int SET_W  = cursor_width(L2_SETS);
   localparam int WAY_W  = cursor_width(L2_WAYS);
   localparam int REQS_W = cursor_width(N_REQS);

   // decoder strobes and mode
   logic                set_ongoing_flush;
   logic                flush_wb_only;
   logic                incr_flush_set;
   logic                clr_flush_set;
   logic                clr_flush_way;
   logic                clr_ongoing_flush;
   logic                flush_done;

   // datapath progress and request-slot occupancy
   logic                way_done;
   logic                way_evict;
   logic [REQS_W-1:0]   reqs_cnt;

   // flush state back to the decoder
   logic                ongoing_flush;
   logic [SET_W-1:0]    flush_set;
   logic [WAY_W-1:0]    flush_way;
   logic                flush_mode_wb_only;
   logic [CNT_BITS-1:0] flush_evict_cnt;

   // completion handshake and status
   logic                l2_flush_done_valid;
   logic                l2_flush_done_ready;
   logic                flush_busy;
   logic                protocol_err;

   modport master (
      output set_ongoing_flush, flush_wb_only, incr_flush_set, clr_flush_set,
             clr_flush_way, clr_ongoing_flush, flush_done, way_done, way_evict,
             reqs_cnt, l2_flush_done_ready,
      input  ongoing_flush, flush_set, flush_way, flush_mode_wb_only,
             flush_evict_cnt, l2_flush_done_valid, flush_busy, protocol_err
   );

   modport slave (
      input  set_ongoing_flush, flush_wb_only, incr_flush_set, clr_flush_set,
             clr_flush_way, clr_ongoing_flush, flush_done, way_done, way_evict,
             reqs_cnt, l2_flush_done_ready,
      output ongoing_flush, flush_set, flush_way, flush_mode_wb_only,
             flush_evict_cnt, l2_flush_done_valid, flush_busy, protocol_err
   );

endinterface

// File: rtl/l2_flush_ctrl.sv
// L2 flush controller: owns the ongoing-flush flag, set/way scan cursors,
// flush mode and eviction count, waits for outstanding writebacks to drain
// and returns a flush-done handshake. Every output comes straight from a flop.
module l2_flush_ctrl
   import l2_flush_ctrl_pkg::*;
#(
   parameter int L2_SETS  = L2_SETS_DFLT,
   parameter int L2_WAYS  = L2_WAYS_DFLT,
   parameter int N_REQS   = N_REQS_DFLT,
   parameter int CNT_BITS = CNT_BITS_DFLT
) (
   input  logic              clk,
   input  logic              rst,
   l2_flush_ctrl_if.slave    bus
);

   localparam int SET_W  = cursor_width(L2_SETS);
   localparam int WAY_W  = cursor_width(L2_WAYS);
   localparam int REQS_W = cursor_width(N_REQS);

   // Saturating increment of the eviction counter: it sticks at all-ones.
   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
      if (v == {CNT_BITS{1'b1}}) begin
         return v;
      end else begin
         return v + CNT_BITS'(1'b1);
      end
   endfunction

   l2_flush_state_t     state_r,   state_nxt_s;
   logic                ongoing_r, ongoing_nxt_s;
   logic [SET_W-1:0]    set_r,     set_nxt_s;
   logic [WAY_W-1:0]    way_r,     way_nxt_s;
   logic                mode_r,    mode_nxt_s;
   logic [CNT_BITS-1:0] cnt_r,     cnt_nxt_s;
   logic                err_r,     err_nxt_s;
   logic                valid_r;
   logic                busy_r;

   logic                scan_strobe_s;
   logic                way_taken_s;
   logic                way_room_s;
   logic                set_room_s;
   logic                err_start_s;
   logic                err_strobe_s;
   logic                err_way_s;
   logic                err_set_s;

   // Next-state and next-value logic for the flush FSM and its state.
   always_comb begin
      state_nxt_s   = state_r;
      ongoing_nxt_s = ongoing_r;
      set_nxt_s     = set_r;
      way_nxt_s     = way_r;
      mode_nxt_s    = mode_r;
      cnt_nxt_s     = cnt_r;
      err_start_s   = 1'b0;
      err_strobe_s  = 1'b0;
      err_way_s     = 1'b0;
      err_set_s     = 1'b0;

      scan_strobe_s = bus.way_done | bus.incr_flush_set | bus.clr_flush_set |
                      bus.clr_flush_way | bus.clr_ongoing_flush | bus.flush_done;
      // a cursor move ordered by the decoder wins over the datapath's way_done
      way_taken_s   = bus.way_done & ~bus.incr_flush_set & ~bus.clr_flush_way;
      way_room_s    = (way_r < WAY_W'(L2_WAYS));
      set_room_s    = (set_r < SET_W'(L2_SETS));

      case (state_r)
         IDLE: begin
            err_strobe_s = scan_strobe_s;
            if (bus.set_ongoing_flush) begin
               state_nxt_s   = SCAN;
               ongoing_nxt_s = 1'b1;
               set_nxt_s     = {SET_W{1'b0}};
               way_nxt_s     = {WAY_W{1'b0}};
               mode_nxt_s    = bus.flush_wb_only;
               cnt_nxt_s     = {CNT_BITS{1'b0}};
            end else begin
               state_nxt_s   = IDLE;
            end
         end

         SCAN: begin
            err_start_s = bus.set_ongoing_flush;
            err_way_s   = way_taken_s & ~way_room_s;
            err_set_s   = bus.incr_flush_set & ~bus.clr_flush_set & ~set_room_s;

            if (bus.clr_flush_way) begin
               way_nxt_s = {WAY_W{1'b0}};
            end else if (way_taken_s && way_room_s) begin
               way_nxt_s = way_r + WAY_W'(1'b1);
            end else begin
               way_nxt_s = way_r;
            end

            if (way_taken_s && way_room_s && bus.way_evict) begin
               cnt_nxt_s = sat_inc(cnt_r);
            end else begin
               cnt_nxt_s = cnt_r;
            end

            if (bus.clr_flush_set) begin
               set_nxt_s = {SET_W{1'b0}};
            end else if (bus.incr_flush_set && set_room_s) begin
               set_nxt_s = set_r + SET_W'(1'b1);
            end else begin
               set_nxt_s = set_r;
            end

            if (bus.clr_ongoing_flush) begin
               ongoing_nxt_s = 1'b0;
            end else begin
               ongoing_nxt_s = ongoing_r;
            end

            if (bus.flush_done) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = SCAN;
            end
         end

         DRAIN: begin
            err_start_s  = bus.set_ongoing_flush;
            err_strobe_s = scan_strobe_s;
            if (bus.reqs_cnt == REQS_W'(N_REQS)) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = DRAIN;
            end
         end

         RESP: begin
            err_start_s  = bus.set_ongoing_flush;
            err_strobe_s = scan_strobe_s;
            if (bus.l2_flush_done_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end

         default: begin
            state_nxt_s   = IDLE;
            ongoing_nxt_s = 1'b0;
         end
      endcase

      err_nxt_s = err_r | err_start_s | err_strobe_s | err_way_s | err_set_s;
   end

   // State register plus all registered outputs; async reset returns to IDLE at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         ongoing_r <= 1'b0;
         set_r     <= {SET_W{1'b0}};
         way_r     <= {WAY_W{1'b0}};
         mode_r    <= 1'b0;
         cnt_r     <= {CNT_BITS{1'b0}};
         err_r     <= 1'b0;
         valid_r   <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         ongoing_r <= ongoing_nxt_s;
         set_r     <= set_nxt_s;
         way_r     <= way_nxt_s;
         mode_r    <= mode_nxt_s;
         cnt_r     <= cnt_nxt_s;
         err_r     <= err_nxt_s;
         valid_r   <= (state_nxt_s == RESP);
         busy_r    <= (state_nxt_s != IDLE);
      end
   end

   assign bus.ongoing_flush       = ongoing_r;
   assign bus.flush_set           = set_r;
   assign bus.flush_way           = way_r;
   assign bus.flush_mode_wb_only  = mode_r;
   assign bus.flush_evict_cnt     = cnt_r;
   assign bus.l2_flush_done_valid = valid_r;
   assign bus.flush_busy          = busy_r;
   assign bus.protocol_err        = err_r;

endmodule

// File: tb/tb_l2_flush_ctrl.sv
// Directed self-checking bench for l2_flush_ctrl: a phase-level model checked
// against the DUT every falling edge, plus hand-computed literal expectations.
module tb_l2_flush_ctrl;
   import l2_flush_ctrl_pkg::*;

   localparam int SETS    = L2_SETS_DFLT;
   localparam int WAYS    = L2_WAYS_DFLT;
   localparam int NREQ    = N_REQS_DFLT;
   localparam int CNTB    = 16;
   localparam int CNT_MAX = (1 << CNTB) - 1;
   localparam int REQS_W  = cursor_width(NREQ);

   localparam int PH_IDLE  = 0;
   localparam int PH_SCAN  = 1;
   localparam int PH_DRAIN = 2;
   localparam int PH_RESP  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks   = 0;
   int failures = 0;
   int hs_cnt   = 0;
   int hs0;

   int m_phase, m_ong, m_set, m_way, m_mode, m_cnt, m_err;

   always #5 clk = ~clk;

   l2_flush_ctrl_if #(.L2_SETS(SETS), .L2_WAYS(WAYS), .N_REQS(NREQ), .CNT_BITS(CNTB)) bus ();

   l2_flush_ctrl #(.L2_SETS(SETS), .L2_WAYS(WAYS), .N_REQS(NREQ), .CNT_BITS(CNTB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_reset();
      m_phase = PH_IDLE; m_ong = 0; m_set = 0; m_way = 0;
      m_mode  = 0;       m_cnt = 0; m_err = 0;
   endtask

   // One clock edge of the flush rules, applied to the inputs seen at that edge.
   task automatic model_step();
      bit any_scan;
      bit way_ok;
      if (rst) begin
         any_scan = bus.way_done || bus.incr_flush_set || bus.clr_flush_set ||
                    bus.clr_flush_way || bus.clr_ongoing_flush || bus.flush_done;
         if (m_phase == PH_IDLE) begin
            if (any_scan) m_err = 1;
            if (bus.set_ongoing_flush) begin
               m_ong = 1; m_set = 0; m_way = 0; m_cnt = 0;
               m_mode = int'(bus.flush_wb_only);
               m_phase = PH_SCAN;
            end
         end else if (m_phase == PH_SCAN) begin
            if (bus.set_ongoing_flush) m_err = 1;
            way_ok = bus.way_done && !bus.clr_flush_way && !bus.incr_flush_set;
            if (way_ok) begin
               if (m_way >= WAYS) m_err = 1;
               else begin
                  m_way = m_way + 1;
                  if (bus.way_evict) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
               end
            end
            if (bus.clr_flush_way) m_way = 0;
            if (bus.clr_flush_set) m_set = 0;
            else if (bus.incr_flush_set) begin
               if (m_set >= SETS) m_err = 1;
               else m_set = m_set + 1;
            end
            if (bus.clr_ongoing_flush) m_ong = 0;
            if (bus.flush_done) m_phase = PH_DRAIN;
         end else begin
            if (bus.set_ongoing_flush || any_scan) m_err = 1;
            if (m_phase == PH_DRAIN && int'(bus.reqs_cnt) == NREQ) m_phase = PH_RESP;
            else if (m_phase == PH_RESP && bus.l2_flush_done_ready) m_phase = PH_IDLE;
         end
      end
   endtask

   task automatic clear_strobes();
      bus.set_ongoing_flush = 1'b0;
      bus.incr_flush_set    = 1'b0;
      bus.clr_flush_set     = 1'b0;
      bus.clr_flush_way     = 1'b0;
      bus.clr_ongoing_flush = 1'b0;
      bus.flush_done        = 1'b0;
      bus.way_done          = 1'b0;
      bus.way_evict         = 1'b0;
   endtask

   // Apply the current inputs at one rising edge, then drop the strobes.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      clear_strobes();
   endtask

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clk) begin
      check("ongoing_flush", int'(bus.ongoing_flush),       m_ong);
      check("flush_set",     int'(bus.flush_set),           m_set);
      check("flush_way",     int'(bus.flush_way),           m_way);
      check("mode_wb_only",  int'(bus.flush_mode_wb_only),  m_mode);
      check("evict_cnt",     int'(bus.flush_evict_cnt),     m_cnt);
      check("done_valid",    int'(bus.l2_flush_done_valid), (m_phase == PH_RESP) ? 1 : 0);
      check("flush_busy",    int'(bus.flush_busy),          (m_phase != PH_IDLE) ? 1 : 0);
      check("protocol_err",  int'(bus.protocol_err),        m_err);
      if (bus.l2_flush_done_valid && bus.l2_flush_done_ready) hs_cnt++;
   end

   initial begin
      model_reset();
      clear_strobes();
      bus.flush_wb_only       = 1'b0;
      bus.reqs_cnt            = REQS_W'(NREQ);
      bus.l2_flush_done_ready = 1'b0;
      #1 rst = 1'b0;
      repeat (3) tick();
      check("rst_busy",  int'(bus.flush_busy), 0);
      check("rst_valid", int'(bus.l2_flush_done_valid), 0);
      check("rst_err",   int'(bus.protocol_err), 0);
      rst = 1'b1;
      tick();

      // full flush, all ways dirty, write-back-only mode
      bus.flush_wb_only = 1'b1; bus.set_ongoing_flush = 1'b1; tick();
      check("start_ongoing", int'(bus.ongoing_flush), 1);
      check("start_busy",    int'(bus.flush_busy), 1);
      check("start_mode",    int'(bus.flush_mode_wb_only), 1);
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) begin
            bus.way_done = 1'b1; bus.way_evict = 1'b1; tick();
         end
         if (s < SETS - 1) begin
            bus.incr_flush_set = 1'b1; bus.clr_flush_way = 1'b1; tick();
            check("scan_set_adv", int'(bus.flush_set), s + 1);
         end else begin
            bus.flush_done = 1'b1; bus.clr_flush_set = 1'b1;
            bus.clr_flush_way = 1'b1; bus.clr_ongoing_flush = 1'b1; tick();
         end
      end
      check("full_cnt",        int'(bus.flush_evict_cnt), 8);
      check("full_valid_d1",   int'(bus.l2_flush_done_valid), 0);
      check("full_ongoing_lo", int'(bus.ongoing_flush), 0);
      tick();
      check("full_valid_d2",   int'(bus.l2_flush_done_valid), 1);
      bus.l2_flush_done_ready = 1'b1; tick();
      bus.l2_flush_done_ready = 1'b0;
      check("full_valid_off",  int'(bus.l2_flush_done_valid), 0);
      check("full_idle",       int'(bus.flush_busy), 0);
      check("full_cnt_hold",   int'(bus.flush_evict_cnt), 8);

      // collision, way overrun, drain wait, error in DRAIN, backpressure
      bus.flush_wb_only = 1'b0; bus.set_ongoing_flush = 1'b1; tick();
      check("f2_cnt_zero", int'(bus.flush_evict_cnt), 0);
      check("f2_mode",     int'(bus.flush_mode_wb_only), 0);
      bus.way_done = 1'b1; bus.way_evict = 1'b1;
      bus.incr_flush_set = 1'b1; bus.clr_flush_way = 1'b1; tick();
      check("coll_way", int'(bus.flush_way), 0);
      check("coll_set", int'(bus.flush_set), 1);
      check("coll_cnt", int'(bus.flush_evict_cnt), 0);
      repeat (2) begin
         bus.way_done = 1'b1; bus.way_evict = 1'b1; tick();
      end
      check("f2_way_full", int'(bus.flush_way), WAYS);
      check("f2_err_pre",  int'(bus.protocol_err), 0);
      bus.way_done = 1'b1; bus.way_evict = 1'b1; tick();
      check("ovr_err", int'(bus.protocol_err), 1);
      check("ovr_way", int'(bus.flush_way), WAYS);
      check("ovr_cnt", int'(bus.flush_evict_cnt), 2);
      check("ovr_set", int'(bus.flush_set), 1);
      bus.flush_done = 1'b1; bus.clr_flush_set = 1'b1;
      bus.clr_flush_way = 1'b1; bus.clr_ongoing_flush = 1'b1; tick();
      bus.reqs_cnt = REQS_W'(NREQ - 2);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) bus.set_ongoing_flush = 1'b1;
         tick();
         check("drain_valid_lo", int'(bus.l2_flush_done_valid), 0);
      end
      check("drain_err",     int'(bus.protocol_err), 1);
      check("drain_busy",    int'(bus.flush_busy), 1);
      check("drain_ongoing", int'(bus.ongoing_flush), 0);
      check("drain_set",     int'(bus.flush_set), 0);
      bus.reqs_cnt = REQS_W'(NREQ); tick();
      check("drain_valid_hi", int'(bus.l2_flush_done_valid), 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_valid_held", int'(bus.l2_flush_done_valid), 1);
      end
      hs0 = hs_cnt;
      bus.l2_flush_done_ready = 1'b1; tick();
      check("bp_valid_drop", int'(bus.l2_flush_done_valid), 0);
      repeat (2) tick();
      bus.l2_flush_done_ready = 1'b0;
      check("bp_one_hs", hs_cnt - hs0, 1);

      // reset in the middle of a scan at set 3, way 1
      bus.flush_wb_only = 1'b1; bus.set_ongoing_flush = 1'b1; tick();
      for (int s = 0; s < 3; s++) begin
         repeat (2) begin
            bus.way_done = 1'b1; tick();
         end
         bus.incr_flush_set = 1'b1; bus.clr_flush_way = 1'b1; tick();
      end
      bus.way_done = 1'b1; tick();
      check("pre_rst_set", int'(bus.flush_set), 3);
      check("pre_rst_way", int'(bus.flush_way), 1);
      @(negedge clk);
      #2 rst = 1'b0;
      model_reset();
      #1;
      check("mid_rst_ongoing", int'(bus.ongoing_flush), 0);
      check("mid_rst_set",     int'(bus.flush_set), 0);
      check("mid_rst_way",     int'(bus.flush_way), 0);
      check("mid_rst_mode",    int'(bus.flush_mode_wb_only), 0);
      check("mid_rst_cnt",     int'(bus.flush_evict_cnt), 0);
      check("mid_rst_valid",   int'(bus.l2_flush_done_valid), 0);
      check("mid_rst_busy",    int'(bus.flush_busy), 0);
      check("mid_rst_err",     int'(bus.protocol_err), 0);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      bus.set_ongoing_flush = 1'b1; tick();
      check("restart_set",  int'(bus.flush_set), 0);
      check("restart_way",  int'(bus.flush_way), 0);
      check("restart_ong",  int'(bus.ongoing_flush), 1);
      check("restart_busy", int'(bus.flush_busy), 1);
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/l2_flush_ctrl.md
# l2_flush_ctrl

Owns the L2 flush state consumed by the L2 input decoder: the ongoing-flush flag, the set/way scan cursors, the flush mode and completion signalling. It sits beside the input decoder. It applies the decoder's set/clear/increment strobes, advances the way cursor as the datapath finishes each way, drains outstanding writebacks after the scan, and returns a flush-done handshake to the CPU side.

## Interface
Parameters:
- L2_SETS, default `L2_SETS: number of sets scanned.
- L2_WAYS, default `L2_WAYS: ways per set.
- N_REQS, default `N_REQS: reqs_cnt value meaning all request slots are free.
- CNT_BITS, default 16: width of the eviction counter.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- set_ongoing_flush  in  1  decoder strobe that starts a flush.
- flush_wb_only  in  1  mode, sampled with set_ongoing_flush: 1 = write back dirty lines only, 0 = write back and invalidate.
- incr_flush_set, clr_flush_set, clr_flush_way, clr_ongoing_flush, flush_done  in  1 each  decoder strobes.
- way_done  in  1  datapath finished the way at flush_way.
- way_evict  in  1  qualifies way_done: that line was written back.
- reqs_cnt  in  `REQS_BITS_P1  free request slots.
- ongoing_flush  out  1  flag to the decoder.
- flush_set  out  `L2_SET_BITS+1  set cursor.
- flush_way  out  `L2_WAY_BITS+1  way cursor.
- flush_mode_wb_only  out  1  captured mode.
- flush_evict_cnt  out  CNT_BITS  evictions in the current or last flush.
- l2_flush_done_valid  out  1  completion to the CPU side.
- l2_flush_done_ready  in  1  completion accept.
- flush_busy  out  1  state is not IDLE.
- protocol_err  out  1  sticky error flag.

## Operation
FSM states: IDLE, SCAN, DRAIN, RESP.

- **IDLE**
  - On set_ongoing_flush: ongoing_flush<=1, flush_set<=0, flush_way<=0, capture flush_wb_only, flush_evict_cnt<=0, go to SCAN.
- **SCAN**
  - way_done with flush_way<L2_WAYS: flush_way+1. If way_evict is also high, flush_evict_cnt+1, saturating at all-ones.
  - incr_flush_set: flush_set+1. clr_flush_way: flush_way<=0. Both act in the same cycle as the decoder issues them.
  - clr_flush_set and clr_flush_way: set and way <=0.
  - clr_ongoing_flush: ongoing_flush<=0.
  - flush_done: go to DRAIN. It always arrives together with the three clears.
- **DRAIN**
  - When reqs_cnt==N_REQS: go to RESP.
- **RESP**
  - l2_flush_done_valid=1. On l2_flush_done_ready: go to IDLE. flush_evict_cnt holds until the next flush starts.

Priority and boundary cases:
- Simultaneous strobes: clr_flush_way or incr_flush_set beats way_done in the same cycle. way_done is dropped and does not count.
- way_done when flush_way==L2_WAYS: ignored, protocol_err<=1.
- set_ongoing_flush outside IDLE: ignored, protocol_err<=1.
- Any SCAN strobe (way_done, incr_flush_set, clr_flush_way, clr_flush_set, clr_ongoing_flush, flush_done) outside SCAN: ignored, protocol_err<=1.
- flush_set never exceeds L2_SETS. An incr_flush_set at L2_SETS is ignored and sets protocol_err.
- protocol_err clears only on reset.
- Reset mid-operation: immediate return to IDLE. Reset values:
  - ongoing_flush=0, flush_set=0, flush_way=0.
  - flush_mode_wb_only=0, flush_evict_cnt=0.
  - l2_flush_done_valid=0, flush_busy=0, protocol_err=0.

## Timing
- All outputs are registered. Every strobe takes effect on the next rising clk edge.
- ongoing_flush=1 and flush_busy=1 from the cycle after set_ongoing_flush.
- The cursors show an update the cycle after its strobe. The decoder sees the new flush_way in its following decode.
- DRAIN to RESP: l2_flush_done_valid rises the cycle after reqs_cnt==N_REQS is sampled in DRAIN.
- Minimum latency from flush_done to valid: 2 cycles.
- valid stays high until ready is sampled high. It drops the cycle after acceptance.
- ready while valid is low: no effect.
- No combinational path from any input to any output.

## Structure
- cache_consts.svh: L2_SETS, L2_WAYS, N_REQS, L2_SET_BITS, L2_WAY_BITS, REQS_BITS_P1.
- cache_types.svh: l2_flush_state_t enum {IDLE, SCAN, DRAIN, RESP}.
- Single module, no sub-module. The saturating counter is small enough to stay inline.

## Test plan
- Full flush, 4 sets × 2 ways, all dirty, reqs_cnt at N_REQS:
  - 8 way_done+way_evict pulses with matching incr/clr strobes, then flush_done.
  - Expect flush_evict_cnt=8, valid 2 cycles after flush_done. ready → IDLE, flush_busy=0.
- Drain wait:
  - Hold reqs_cnt=N_REQS-2 for 5 cycles after flush_done, then raise it to N_REQS.
  - Expect valid low throughout, high on the next cycle.
- Collision:
  - way_done+way_evict in the same cycle as incr_flush_set+clr_flush_way.
  - Expect flush_way=0, flush_set+1, count unchanged.
- Errors:
  - way_done at flush_way=L2_WAYS.
  - set_ongoing_flush during DRAIN.
  - Expect protocol_err=1 after each, with cursors and state unchanged.
- Backpressure:
  - ready low for 10 cycles in RESP.
  - Expect valid held, then exactly one handshake.
- Reset during SCAN at set 3 way 1:
  - Expect all outputs at reset values the same cycle rst falls.
  - A new set_ongoing_flush after reset starts at set 0 way 0.
